mc_controller: RTL and testbench

- Multicycle control unit sitting directly upstream of the 32-bit ALU.
- Decodes op/funct from the instruction register and sequences FETCH/DECODE/execute/writeback states.
- Drives the ALU function code F[2:0] plus all datapath mux selects and write enables.
- Supports a memory ready handshake so fetch, load and store can stall on slow memory.

---
 rtl/mc_controller.sv | 182 ++++++++++++++++++
 tb/tb_mc_controller.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multicycle MIPS-style control FSM driving ALU function code, datapath mux selects and write enables.
// Latency: lw 5, sw 4, R-type/addi 4, beq/j 3 cycles; each memory wait cycle adds one.
// Backpressure: FETCH, MEMRD and MEMWR hold while mem_ready is low (ignored when MEM_WAIT_EN=0).
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   op, funct           instruction fields from the IR (stable from the FETCH edge onward)
//   zero, mem_ready     ALU zero flag, memory access completes this cycle
//   alucontrol          ALU F code (000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT)
//   alusrca/alusrcb     ALU operand selects
//   iord, irwrite, memwrite, regdst, memtoreg, regwrite, pcsrc, pcen  datapath controls
//   illegal             one-cycle pulse in DECODE on an unsupported op/funct
//   state               current state encoding, for debug
module mc_controller #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] alucontrol,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       w_rdy;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_irwrite;
  logic       w_memwrite;
  logic       w_regwrite;
  logic       w_illegal;
  logic       w_funct_ok;
  logic [2:0] w_rtype_f;

  assign w_rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // R-type funct decode, shared by DECODE (legality) and RTYPEEX (ALU code)
  always_comb begin
    w_funct_ok = 1'b1;
    w_rtype_f  = 3'b010;
    case (funct)
      6'b100000: w_rtype_f = 3'b010;
      6'b100010: w_rtype_f = 3'b110;
      6'b100100: w_rtype_f = 3'b000;
      6'b100101: w_rtype_f = 3'b001;
      6'b101010: w_rtype_f = 3'b111;
      default:   w_funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_next     = S_FETCH;
    alucontrol = 3'b010;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    iord       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    pcsrc      = 2'b00;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_irwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_regwrite = 1'b0;
    w_illegal  = 1'b0;
    case (r_state)
      S_FETCH: begin
        alusrcb = 2'b01;
        if (w_rdy) begin
          w_irwrite = 1'b1;
          w_pcwrite = 1'b1;
          w_next    = S_DECODE;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          6'b100011, 6'b101011: w_next = S_MEMADR;
          6'b000000: begin
            if (w_funct_ok) w_next = S_RTYPEEX;
            else            w_illegal = 1'b1;
          end
          6'b000100: w_next = S_BEQEX;
          6'b001000: w_next = S_ADDIEX;
          6'b000010: w_next = S_JEX;
          default:   w_illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = (op == 6'b100011) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord   = 1'b1;
        w_next = w_rdy ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        w_regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        w_memwrite = 1'b1;
        w_next     = w_rdy ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        alusrca    = 1'b1;
        alucontrol = w_rtype_f;
        w_next     = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst     = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BEQEX: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
        w_branch   = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: w_regwrite = 1'b1;
      S_JEX: begin
        pcsrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
      // encodings 12-15: fall back to FETCH with every enable low
      default: w_next = S_FETCH;
    endcase
  end

  // enables are squashed combinationally during reset so nothing writes in the reset cycle
  assign irwrite  = w_irwrite  & rst_n;
  assign memwrite = w_memwrite & rst_n;
  assign regwrite = w_regwrite & rst_n;
  assign illegal  = w_illegal  & rst_n;
  assign pcen     = (w_pcwrite | (w_branch & zero)) & rst_n;
  assign state    = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: instruction-level reference model with random stalls.
// Latency: n/a.
// Backpressure: mem_ready stall schedule driven per instruction.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic [2:0] alucontrol;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       iord;
  logic       irwrite;
  logic       memwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic [1:0] pcsrc;
  logic       pcen;
  logic       illegal;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3, K_ADDI = 4, K_J = 5, K_ILL = 6;

  always #5 clk = ~clk;

  mc_controller #(.MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .alucontrol(alucontrol), .alusrca(alusrca), .alusrcb(alusrcb), .iord(iord),
    .irwrite(irwrite), .memwrite(memwrite), .regdst(regdst), .memtoreg(memtoreg),
    .regwrite(regwrite), .pcsrc(pcsrc), .pcen(pcen), .illegal(illegal), .state(state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] alu_of_funct(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic bit legal_funct(input logic [5:0] f);
    return f == 6'b100000 || f == 6'b100010 || f == 6'b100100 || f == 6'b100101 || f == 6'b101010;
  endfunction

  function automatic bit legal_op(input logic [5:0] o);
    return o == 6'b100011 || o == 6'b101011 || o == 6'b000000 || o == 6'b000100 ||
           o == 6'b001000 || o == 6'b000010;
  endfunction

  // Runs one instruction from a FETCH cycle (called mid-cycle) and compares instruction-level
  // totals against the model: latency, write counts, and key controls in the execute cycle.
  task automatic run_instr(input int kind, input logic [5:0] o, input logic [5:0] f,
                           input logic z, input int kf, input int km);
    bit   is_mem, done, seen_ir;
    int   exp_cyc, exp_rw, exp_mw, exp_pcen, exp_ex_state, i;
    int   n_ir, n_rw, n_mw, n_pcen, n_ill;
    logic [2:0] exp_alu, ex_alu;
    logic [3:0] ex_state;
    logic rw_regdst, rw_memtoreg;
    logic [1:0] br_pcsrc;

    is_mem = (kind == K_LW) || (kind == K_SW);
    case (kind)
      K_LW:    begin exp_cyc = 5; exp_ex_state = 2;  exp_alu = 3'b010; end
      K_SW:    begin exp_cyc = 4; exp_ex_state = 2;  exp_alu = 3'b010; end
      K_R:     begin exp_cyc = 4; exp_ex_state = 6;  exp_alu = alu_of_funct(f); end
      K_BEQ:   begin exp_cyc = 3; exp_ex_state = 8;  exp_alu = 3'b110; end
      K_ADDI:  begin exp_cyc = 4; exp_ex_state = 9;  exp_alu = 3'b010; end
      K_J:     begin exp_cyc = 3; exp_ex_state = 11; exp_alu = 3'b010; end
      default: begin exp_cyc = 2; exp_ex_state = 0;  exp_alu = 3'b010; end
    endcase
    exp_cyc  = exp_cyc + kf + (is_mem ? km : 0);
    exp_rw   = (kind == K_LW || kind == K_R || kind == K_ADDI) ? 1 : 0;
    exp_mw   = (kind == K_SW) ? km + 1 : 0;
    exp_pcen = 1 + ((kind == K_BEQ && z) ? 1 : 0) + ((kind == K_J) ? 1 : 0);

    op = o; funct = f; zero = z;
    done = 0; seen_ir = 0; i = 0;
    n_ir = 0; n_rw = 0; n_mw = 0; n_pcen = 0; n_ill = 0;
    ex_alu = 3'b0; ex_state = 4'hf; rw_regdst = 1'b0; rw_memtoreg = 1'b0; br_pcsrc = 2'b00;

    check("start_state", 32'(state), 0);
    while (!done && i < 64) begin
      mem_ready = !((i < kf) || (is_mem && i >= kf + 3 && i < kf + 3 + km));
      #1;
      if (seen_ir && state == 4'd0) begin
        done = 1;
      end else begin
        if (irwrite)  begin n_ir++; seen_ir = 1; end
        if (memwrite) n_mw++;
        if (illegal)  n_ill++;
        if (regwrite) begin n_rw++; rw_regdst = regdst; rw_memtoreg = memtoreg; end
        if (pcen) begin n_pcen++; if (!irwrite) br_pcsrc = pcsrc; end
        if (i == kf + 2) begin ex_state = state; ex_alu = alucontrol; end
        @(posedge clk); #2;
        i++;
      end
    end
    check("timeout", 32'(done), 1);
    check("latency", i, exp_cyc);
    check("irwrite_cnt", n_ir, 1);
    check("regwrite_cnt", n_rw, exp_rw);
    check("memwrite_cnt", n_mw, exp_mw);
    check("pcen_cnt", n_pcen, exp_pcen);
    check("illegal_cnt", n_ill, (kind == K_ILL) ? 1 : 0);
    if (kind != K_ILL) begin
      check("exec_state", 32'(ex_state), exp_ex_state);
      check("exec_alu", 32'(ex_alu), 32'(exp_alu));
    end
    if (exp_rw == 1) begin
      check("wb_regdst", 32'(rw_regdst), (kind == K_R) ? 1 : 0);
      check("wb_memtoreg", 32'(rw_memtoreg), (kind == K_LW) ? 1 : 0);
    end
    if (kind == K_J || (kind == K_BEQ && z))
      check("pc_src", 32'(br_pcsrc), (kind == K_J) ? 2 : 1);
  endtask

  task automatic run_random();
    int k;
    logic [5:0] o, f;
    k = $urandom_range(0, 6);
    f = 6'($urandom);
    case (k)
      K_LW:   o = 6'b100011;
      K_SW:   o = 6'b101011;
      K_R: begin
        o = 6'b000000;
        case ($urandom_range(0, 4))
          0: f = 6'b100000; 1: f = 6'b100010; 2: f = 6'b100100;
          3: f = 6'b100101; default: f = 6'b101010;
        endcase
      end
      K_BEQ:  o = 6'b000100;
      K_ADDI: o = 6'b001000;
      K_J:    o = 6'b000010;
      default: begin
        if ($urandom_range(0, 1) == 0) begin
          o = 6'b000000;
          while (legal_funct(f)) f = 6'($urandom);
        end else begin
          o = 6'($urandom);
          while (legal_op(o)) o = 6'($urandom);
        end
      end
    endcase
    run_instr(k, o, f, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; op = 6'b0; funct = 6'b0; zero = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    #1;
    check("rst_state", 32'(state), 0);
    check("rst_pcen", 32'(pcen), 0);
    check("rst_irwrite", 32'(irwrite), 0);
    check("rst_regwrite", 32'(regwrite), 0);
    check("rst_memwrite", 32'(memwrite), 0);
    rst_n = 1'b1;
    #1;
    check("rel_irwrite", 32'(irwrite), 1);
    check("rel_pcen", 32'(pcen), 1);
    check("rel_alu", 32'(alucontrol), 2);

    // directed cases from the test plan
    run_instr(K_R,    6'b000000, 6'b100010, 1'b0, 0, 0);
    run_instr(K_R,    6'b000000, 6'b101010, 1'b0, 0, 0);
    run_instr(K_LW,   6'b100011, 6'b000000, 1'b0, 0, 3);
    run_instr(K_BEQ,  6'b000100, 6'b000000, 1'b1, 0, 0);
    run_instr(K_BEQ,  6'b000100, 6'b000000, 1'b0, 0, 0);
    run_instr(K_ILL,  6'b111111, 6'b000000, 1'b0, 0, 0);
    run_instr(K_J,    6'b000010, 6'b000000, 1'b0, 0, 0);
    run_instr(K_SW,   6'b101011, 6'b000000, 1'b0, 1, 2);
    run_instr(K_ADDI, 6'b001000, 6'b000000, 1'b1, 0, 0);

    // sw abandoned by reset while waiting in MEMWR
    op = 6'b101011; mem_ready = 1'b1;
    @(posedge clk); #2;
    mem_ready = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #3;
    check("sw_in_memwr", 32'(state), 5);
    check("sw_memwrite", 32'(memwrite), 1);
    rst_n = 1'b0;
    #1;
    check("sw_rst_memwrite", 32'(memwrite), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
    check("sw_rst_state", 32'(state), 0);

    for (int n = 0; n < 40; n++) run_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
